// File: rtl/riscv_str_alu_pkg.sv
// Shared definitions for the string execution unit: operator codes and FSM states.
package riscv_defines;

    localparam int STR_OP_WIDTH = 2;

    localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 2'b00;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 2'b01;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 2'b10;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 2'b11;

    typedef enum logic [1:0] {
        STR_IDLE,
        STR_BUSY,
        STR_DONE
    } str_alu_state_e;

endpackage

// File: rtl/riscv_str_alu_byte_xform.sv
// Combinational per-character transform for the string ops; holds every character table.
module riscv_str_byte_xform
    import riscv_defines::*;
(
    input  logic [STR_OP_WIDTH-1:0] i_op,
    input  logic [7:0]              i_byte,
    output logic [7:0]              o_byte
);

    logic       w_is_lower;
    logic       w_is_upper;
    logic [7:0] w_folded;

    assign w_is_lower = (i_byte >= 8'h61) && (i_byte <= 8'h7A);
    assign w_is_upper = (i_byte >= 8'h41) && (i_byte <= 8'h5A);
    // Only meaningful for letters: maps 'A'..'Z' onto 'a'..'z'
    assign w_folded   = i_byte | 8'h20;

    always_comb begin
        o_byte = i_byte;
        unique case (i_op)
            STR_OP_UPPER: if (w_is_lower) o_byte = i_byte - 8'h20;
            STR_OP_LOWER: if (w_is_upper) o_byte = i_byte + 8'h20;
            STR_OP_LEET: begin
                if (w_is_lower || w_is_upper) begin
                    case (w_folded)
                        8'h61:   o_byte = 8'h34;
                        8'h65:   o_byte = 8'h33;
                        8'h69:   o_byte = 8'h31;
                        8'h6F:   o_byte = 8'h30;
                        8'h73:   o_byte = 8'h35;
                        8'h74:   o_byte = 8'h37;
                        default: o_byte = i_byte;
                    endcase
                end
            end
            STR_OP_ROT13: begin
                // First half of each alphabet moves up 13, second half wraps down 13
                if (w_is_lower)
                    o_byte = (i_byte <= 8'h6D) ? i_byte + 8'd13 : i_byte - 8'd13;
                else if (w_is_upper)
                    o_byte = (i_byte <= 8'h4D) ? i_byte + 8'd13 : i_byte - 8'd13;
            end
            default: o_byte = i_byte;
        endcase
    end

endmodule

// File: rtl/riscv_str_alu.sv
// Byte-serial string ALU: accepts a word, transforms one byte per cycle LSB first,
// then holds the result until the EX stage takes it.
module riscv_str_alu
    import riscv_defines::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]             operand_i,
    input  logic                    clear_i,
    input  logic                    ex_ready_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [31:0]             result_o,
    output logic                    null_found_o
);

    str_alu_state_e          r_state;
    str_alu_state_e          w_state_next;
    logic [1:0]              r_idx;
    logic [STR_OP_WIDTH-1:0] r_op;
    logic [31:0]             r_work;
    logic                    r_null;
    logic [7:0]              w_byte_in;
    logic [7:0]              w_byte_out;

    assign w_byte_in = r_work[{r_idx, 3'b000} +: 8];

    riscv_str_byte_xform u_xform (
        .i_op   (r_op),
        .i_byte (w_byte_in),
        .o_byte (w_byte_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= STR_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            STR_IDLE: if (enable_i)        w_state_next = STR_BUSY;
            STR_BUSY: if (r_idx == 2'd3)   w_state_next = STR_DONE;
            STR_DONE: if (ex_ready_i)      w_state_next = STR_IDLE;
            default:                       w_state_next = STR_IDLE;
        endcase
        if (clear_i) w_state_next = STR_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= 2'd0;
            r_op   <= STR_OP_UPPER;
            r_work <= 32'd0;
            r_null <= 1'b0;
        end else if (!clear_i) begin
            if (r_state == STR_IDLE && enable_i) begin
                r_idx  <= 2'd0;
                r_op   <= operator_i;
                r_work <= operand_i;
                r_null <= 1'b0;
            end else if (r_state == STR_BUSY) begin
                // Once a NUL is seen the rest of the word is left untouched
                if (w_byte_in == 8'h00)
                    r_null <= 1'b1;
                else if (!r_null)
                    r_work[{r_idx, 3'b000} +: 8] <= w_byte_out;
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    assign ready_o      = (r_state == STR_IDLE);
    assign valid_o      = (r_state == STR_DONE);
    assign result_o     = r_work;
    assign null_found_o = r_null;

endmodule

// File: tb/tb_riscv_str_alu.sv
// Scoreboard bench for riscv_str_alu: stimulus pushes model results, a monitor checks on valid_o.
module tb_riscv_str_alu;
    import riscv_defines::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0;
    logic [1:0]  operator_i = 2'b00;
    logic [31:0] operand_i = 32'd0;
    logic        clear_i = 1'b0;
    logic        ex_ready_i = 1'b0;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic        null_found_o;

    riscv_str_alu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .operator_i   (operator_i),
        .operand_i    (operand_i),
        .clear_i      (clear_i),
        .ex_ready_i   (ex_ready_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .result_o     (result_o),
        .null_found_o (null_found_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] src;
        logic [31:0] res;
        logic        nul;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_v = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: walk the word as four characters, stop transforming at the first NUL
    function automatic logic [32:0] ref_model(input logic [1:0] op, input logic [31:0] w);
        logic [31:0] r = w;
        bit          stop = 0;
        int          c;
        for (int i = 0; i < 4; i++) begin
            c = int'(w[8*i +: 8]);
            if (stop) continue;
            if (c == 0) begin
                stop = 1;
                continue;
            end
            case (op)
                2'b00: if (c >= 97 && c <= 122) c = c - 32;
                2'b01: if (c >= 65 && c <= 90)  c = c + 32;
                2'b10: case (c)
                           97, 65:  c = 52;
                           101, 69: c = 51;
                           105, 73: c = 49;
                           111, 79: c = 48;
                           115, 83: c = 53;
                           116, 84: c = 55;
                           default: ;
                       endcase
                default: begin
                    if (c >= 97 && c <= 122)     c = (c - 97 + 13) % 26 + 97;
                    else if (c >= 65 && c <= 90) c = (c - 65 + 13) % 26 + 65;
                end
            endcase
            r[8*i +: 8] = 8'(c);
        end
        return {stop, r};
    endfunction

    function automatic logic [7:0] rand_byte();
        int k = int'($urandom_range(0, 99));
        if (k < 6)  return 8'h00;
        if (k < 40) return 8'(97 + $urandom_range(0, 25));
        if (k < 75) return 8'(65 + $urandom_range(0, 25));
        return 8'($urandom_range(1, 255));
    endfunction

    // Monitor: compare the head of the scoreboard every cycle valid_o is up
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v <= 1'b0;
        end else begin
            if (valid_o) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid actual=%h required=no_result", result_o);
                end else begin
                    chk("result", result_o, sb[0].res);
                    chk("null_found", {31'd0, null_found_o}, {31'd0, sb[0].nul});
                    if (!prev_v) chk("latency", 32'(cyc - sb[0].acc), 32'd4);
                    if (ex_ready_i) begin
                        $display("txn op=%0d in=%h out=%h nul=%0d", sb[0].op, sb[0].src,
                                 result_o, null_found_o);
                        void'(sb.pop_front());
                    end
                end
            end
            prev_v <= valid_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] w, input int hold, input bit pulse);
        exp_t        e;
        logic [32:0] m;
        int          k;
        k = 0;
        while (!ready_o && k < 20) begin step(); k++; end
        if (!ready_o) chk("ready_timeout", 32'(ready_o), 32'd1);
        enable_i   = 1'b1;
        operator_i = op;
        operand_i  = w;
        step();
        enable_i = 1'b0;
        m     = ref_model(op, w);
        e.op  = op;
        e.src = w;
        e.res = m[31:0];
        e.nul = m[32];
        e.acc = cyc;
        sb.push_back(e);
        operator_i = 2'($urandom);
        operand_i  = $urandom;
        if (pulse) begin
            enable_i = 1'b1;
            step();
            enable_i = 1'b0;
        end
        k = 0;
        while (!valid_o && k < 20) begin step(); k++; end
        if (!valid_o) begin
            chk("valid_timeout", 32'(valid_o), 32'd1);
            sb.delete();
        end
        for (int h = 0; h < hold; h++) begin
            step();
            chk("valid_hold", 32'(valid_o), 32'd1);
        end
        ex_ready_i = 1'b1;
        step();
        ex_ready_i = 1'b0;
        chk("ready_after_hs", 32'(ready_o), 32'd1);
        chk("valid_after_hs", 32'(valid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit seen_v;
        repeat (3) step();
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_null", 32'(null_found_o), 32'd0);
        rst_n = 1'b1;
        step();

        do_op(STR_OP_UPPER, 32'h64636261, 0, 0);
        do_op(STR_OP_ROT13, 32'h5A417A6E, 0, 0);
        do_op(STR_OP_ROT13, 32'h2131392E, 1, 0);
        do_op(STR_OP_LEET,  32'h74736574, 0, 0);
        do_op(STR_OP_LOWER, 32'h5A5B4140, 0, 0);
        do_op(STR_OP_UPPER, 32'h61006263, 0, 0);
        do_op(STR_OP_UPPER, 32'h00000000, 0, 0);
        do_op(STR_OP_UPPER, 32'h64636261, 3, 0);
        do_op(STR_OP_UPPER, 32'h64636261, 0, 1);

        // Abort with clear_i while byte 2 is next
        enable_i = 1'b1; operator_i = STR_OP_UPPER; operand_i = 32'h64636261;
        step();
        enable_i = 1'b0;
        step();
        step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clear_ready", 32'(ready_o), 32'd1);
        chk("clear_valid", 32'(valid_o), 32'd0);
        seen_v = 0;
        repeat (6) begin step(); seen_v |= valid_o; end
        chk("clear_no_valid", 32'(seen_v), 32'd0);
        do_op(STR_OP_UPPER, 32'h64636261, 0, 0);

        // Asynchronous reset between edges while busy
        enable_i = 1'b1; operator_i = STR_OP_LEET; operand_i = 32'h74736574;
        step();
        enable_i = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 32'(ready_o), 32'd1);
        chk("async_rst_valid", 32'(valid_o), 32'd0);
        chk("async_rst_result", result_o, 32'd0);
        #3 rst_n = 1'b1;
        step();
        do_op(STR_OP_UPPER, 32'h64636261, 0, 0);

        // clear_i together with enable_i in IDLE drops the request
        enable_i = 1'b1; clear_i = 1'b1;
        step();
        enable_i = 1'b0; clear_i = 1'b0;
        chk("clear_enable_drop", 32'(ready_o), 32'd1);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] w;
            for (int b = 0; b < 4; b++) w[8*b +: 8] = rand_byte();
            do_op(2'($urandom), w, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        repeat (3) step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
